// File: rtl/goldschmidt_pkg.sv
// Shared types, constants and product renormalization for the Goldschmidt divider sequencer.
package goldschmidt_pkg;

  localparam int unsigned GS_W    = 16;
  localparam int unsigned PHASE_W = 3;

  localparam logic [GS_W-1:0] ONE_Q = 16'h4000;
  localparam logic [GS_W-1:0] TWO_Q = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_N,
    ISSUE_D,
    CAPTURE_D,
    DONE,
    ERR
  } gs_state_e;

  typedef struct packed {
    logic            ovf;
    logic [GS_W-1:0] val;
  } renorm_t;

  // Q4.28 product back to Q2.14; integer bits beyond 2 saturate and flag overflow
  function automatic renorm_t renorm(input logic [2*GS_W-1:0] p);
    renorm_t r;
    r.ovf = |p[2*GS_W-1:2*GS_W-2];
    r.val = r.ovf ? '1 : p[2*GS_W-3:GS_W-2];
    return r;
  endfunction

endpackage

// File: rtl/gs_phase_counter.sv
// Refinement phase counter: clear on load, step on inc, terminal count at ITER.
module gs_phase_counter
  import goldschmidt_pkg::*;
#(
  parameter int unsigned ITER = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic tc_c
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = '0;
    end else if (inc) begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tc_c = (phase_q == PHASE_W'(ITER));

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt division sequencer and operand store; issues N then D per phase and
// captures the renormalized products. Optional macro GS_EARLY_EXIT_EN stops once D == 1.0.
module goldschmidt_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int unsigned ITER = 3,
  parameter int unsigned W    = GS_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   n_in,
  input  logic [W-1:0]   d_in,
  input  logic [W-1:0]   ia_in,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           ovf,
  output logic [W-1:0]   quotient,
  output logic [2*W-1:0] dp_n,
  output logic [2*W-1:0] dp_d,
  output logic [W-1:0]   dp_ia,
  output logic [2*W-1:0] dp_prev_k,
  output logic           dp_ksel,
  output logic           dp_ndsel,
  input  logic [2*W-1:0] dp_result
);

  gs_state_e    state_q, state_d;
  logic [W-1:0] n_q, n_d, d_q, d_d, ia_q, ia_d, quot_q, quot_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic         ksel_q, ksel_d, ndsel_q, ndsel_d;
  logic         ph_load, ph_inc, ph_tc, early_c;
  renorm_t      rn;

  gs_phase_counter #(.ITER(ITER)) u_phase (
    .clk   (clk),
    .reset (reset),
    .load  (ph_load),
    .inc   (ph_inc),
    .tc_c  (ph_tc)
  );

  assign rn = renorm(dp_result);

`ifdef GS_EARLY_EXIT_EN
  assign early_c = (rn.val == ONE_Q);
`else
  assign early_c = 1'b0;
`endif

  // Next state, operand capture and registered output decode from the next state
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    ia_d    = ia_q;
    quot_d  = quot_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    ph_load = 1'b0;
    ph_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_in;
          d_d     = d_in;
          ia_d    = ia_in;
          ph_load = 1'b1;
          ovf_d   = 1'b0;
          err_d   = (d_in[W-1:W-2] != 2'b01);
          state_d = err_d ? ERR : ISSUE_N;
        end
      end
      ISSUE_N: state_d = ISSUE_D;
      ISSUE_D: begin
        n_d     = rn.val;
        ovf_d   = ovf_q | rn.ovf;
        state_d = CAPTURE_D;
      end
      CAPTURE_D: begin
        d_d   = rn.val;
        ovf_d = ovf_q | rn.ovf;
        if (ph_tc || early_c) begin
          state_d = DONE;
        end else begin
          ph_inc  = 1'b1;
          state_d = ISSUE_N;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == ISSUE_N) || (state_d == ISSUE_D) || (state_d == CAPTURE_D);
    done_d  = (state_d == DONE) || (state_d == ERR);
    ndsel_d = (state_d == ISSUE_D);
    if (state_d == DONE) quot_d = n_q;
    if (state_d == ERR)  quot_d = '0;

    // k select is held across both issues of a phase; only phase 0 uses IA
    case (state_d)
      ISSUE_N: ksel_d = (state_q == CAPTURE_D);
      ISSUE_D: ksel_d = ksel_q;
      default: ksel_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      ia_q    <= '0;
      quot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ksel_q  <= 1'b0;
      ndsel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      ia_q    <= ia_d;
      quot_q  <= quot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      ksel_q  <= ksel_d;
      ndsel_q <= ndsel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign quotient  = quot_q;
  assign dp_n      = {{W{1'b0}}, n_q};
  assign dp_d      = {{W{1'b0}}, d_q};
  assign dp_ia     = ia_q;
  assign dp_prev_k = {{W{1'b0}}, d_q};
  assign dp_ksel   = ksel_q;
  assign dp_ndsel  = ndsel_q;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Bench for goldschmidt_ctrl: registered multiply datapath model plus a phase-level
// reference divider; honours GS_EARLY_EXIT_EN when defined.
module tb_goldschmidt_ctrl;
  import goldschmidt_pkg::*;

  localparam int unsigned ITER = 3;
  localparam int unsigned W    = 16;
`ifdef GS_EARLY_EXIT_EN
  localparam int EXP_LAT1 = 4;
`else
  localparam int EXP_LAT1 = 13;
`endif

  logic           clk, reset, start;
  logic [W-1:0]   n_in, d_in, ia_in;
  logic           busy, done, err, ovf;
  logic [W-1:0]   quotient, dp_ia;
  logic [2*W-1:0] dp_n, dp_d, dp_prev_k, dp_result;
  logic           dp_ksel, dp_ndsel;
  logic [W-1:0]   k_c, opnd_c;

  int n_chk  = 0;
  int n_pass = 0;

  goldschmidt_ctrl #(.ITER(ITER), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .quotient(quotient),
    .dp_n(dp_n), .dp_d(dp_d), .dp_ia(dp_ia), .dp_prev_k(dp_prev_k),
    .dp_ksel(dp_ksel), .dp_ndsel(dp_ndsel), .dp_result(dp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: selected operand times k, one-cycle registered product
  assign k_c    = dp_ksel ? W'(TWO_Q - dp_prev_k[W-1:0]) : dp_ia;
  assign opnd_c = dp_ndsel ? dp_d[W-1:0] : dp_n[W-1:0];
  always @(posedge clk) dp_result <= (2*W)'(opnd_c) * (2*W)'(k_c);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference divider: full Goldschmidt refinement with plain integer arithmetic
  function automatic void ref_div(input logic [15:0] n0, d0, ia,
                                  output logic [15:0] q, output bit ov, output int phases);
    logic [15:0] n, d, k;
    logic [31:0] pn, pd;
    n = n0; d = d0; ov = 0; phases = 0;
    for (int p = 0; p <= int'(ITER); p++) begin
      k  = (p == 0) ? ia : 16'(32'h8000 - 32'(d));
      pn = 32'(n) * 32'(k);
      pd = 32'(d) * 32'(k);
      if (pn >= 32'h4000_0000) begin n = 16'hFFFF; ov = 1; end else n = 16'(pn >> 14);
      if (pd >= 32'h4000_0000) begin d = 16'hFFFF; ov = 1; end else d = 16'(pd >> 14);
      phases = p + 1;
`ifdef GS_EARLY_EXIT_EN
      if (d == 16'h4000) break;
`endif
    end
    q = n;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"},  err, 0);
    chk({tag, "_ovf"},  ovf, 0);
    chk({tag, "_quot"}, quotient, 0);
    chk({tag, "_dpn"},  dp_n, 0);
    chk({tag, "_dpd"},  dp_d, 0);
    chk({tag, "_ksel"}, dp_ksel, 0);
    chk({tag, "_ndsel"}, dp_ndsel, 0);
  endtask

  // One request; every cycle up to done+1 is compared against the reference
  task automatic do_op(input logic [15:0] n, d, ia, input bit intrude);
    logic [15:0] q;
    bit ov, bad;
    int ph, lat;
    ref_div(n, d, ia, q, ov, ph);
    bad = (d[15:14] != 2'b01);
    lat = bad ? 1 : 3 * ph + 1;
    @(negedge clk);
    n_in = n; d_in = d; ia_in = ia; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      @(negedge clk);
      if (cyc < lat) begin
        chk("busy_run", busy, 1);
        chk("done_early", done, 0);
        chk("ndsel", dp_ndsel, 32'((cyc - 1) % 3 == 1));
        if ((cyc - 1) % 3 != 2) chk("ksel", dp_ksel, 32'((cyc - 1) / 3 != 0));
        chk("dp_ia", dp_ia, ia);
      end else if (cyc == lat) begin
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("err", err, bad);
        chk("ovf", ovf, bad ? 0 : ov);
        chk("quotient", quotient, bad ? 16'h0 : q);
      end else begin
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
      end
      start = intrude && (lat > 9) && (cyc == 3 || cyc == 7);
      if (start) begin
        n_in = 16'($urandom); d_in = 16'($urandom); ia_in = 16'($urandom);
      end
    end
  endtask

  task automatic reset_abort();
    int seen_done;
    @(negedge clk);
    n_in = 16'h5000; d_in = 16'h5000; ia_in = 16'h3333; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    reset = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("rst_no_done", 32'(seen_done), 0);
  endtask

  initial begin
    logic [15:0] q, n, d, ia;
    bit ov;
    int ph;
    reset = 1'b1; start = 1'b0; n_in = '0; d_in = '0; ia_in = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    ref_div(16'h6000, ONE_Q, 16'h4000, q, ov, ph);
    chk("pin_q1", q, 16'h6000);
    chk("pin_lat1", 32'(3 * ph + 1), 32'(EXP_LAT1));
    ref_div(16'h4000, 16'h6000, 16'h2AAB, q, ov, ph);
    chk("pin_q2_tol", 32'(q >= 16'h2AA9 && q <= 16'h2AAD), 1);
    ref_div(16'h7FFF, 16'h4000, 16'hFFFF, q, ov, ph);
    chk("pin_q3", q, 16'hFFFF);
    chk("pin_ovf3", 32'(ov), 1);

    do_op(16'h6000, ONE_Q, 16'h4000, 0);
    do_op(16'h4000, 16'h6000, 16'h2AAB, 0);
    do_op(16'h6000, 16'h2000, 16'h4000, 0);
    do_op(16'h5000, 16'h5555, 16'h3000, 1);
    do_op(16'h7FFF, 16'h4000, 16'hFFFF, 0);
    reset_abort();
    do_op(16'h6000, ONE_Q, 16'h4000, 0);

    for (int i = 0; i < 40; i++) begin
      n = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
      d = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
      ia = 16'(32'h1000_0000 / 32'(d)) + 16'($urandom_range(0, 16'h200)) - 16'h100;
      case ($urandom_range(0, 9))
        0: d = 16'($urandom);
        1: ia = 16'($urandom);
        default: ;
      endcase
      do_op(n, d, ia, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
